// File: rtl/dibit_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : dibit_serializer_if
// Description : Parallel-load / 2-bit lane bundle for dibit_serializer.
//               master = word source + lane receiver, slave = serializer.
// Revision    : 1.0  initial release
// ============================================================================
interface dibit_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] DATAIN;
   logic             LOAD;
   logic             BUSY;
   logic [1:0]       DATAOUT;
   logic             FRAME;
   logic             LAST;

   modport master (
      output DATAIN, LOAD,
      input  BUSY, DATAOUT, FRAME, LAST
   );

   modport slave (
      input  DATAIN, LOAD,
      output BUSY, DATAOUT, FRAME, LAST
   );
endinterface
`default_nettype wire

// File: rtl/dibit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : dibit_serializer
// Description : Sends a WIDTH-bit word MSB dibit first on a 2-bit lane,
//               followed by an XOR parity dibit and GAP idle cycles.
// Revision    : 1.0  initial release
// ============================================================================
module dibit_serializer #(
   parameter int WIDTH = 8,
   parameter int GAP   = 1
) (
   input  wire logic          clk,
   input  wire logic          reset,
   dibit_serializer_if.slave  bus
);
   localparam int NDIB  = WIDTH / 2;
   localparam int CNT_W = (NDIB > 1) ? $clog2(NDIB) : 1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIB - 1);
   // GAPW is never entered when GAP==0, so the terminal value is irrelevant then
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEND   = 2'd1,
      S_PARITY = 2'd2,
      S_GAPW   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [1:0]       par_q, par_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;

   logic       busy_q, busy_d;
   logic       frame_q, frame_d;
   logic       last_q, last_d;
   logic [1:0] dout_q, dout_d;

   // State, datapath and output registers; reset returns everything to idle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         par_q   <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         busy_q  <= 1'b0;
         frame_q <= 1'b0;
         last_q  <= 1'b0;
         dout_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         busy_q  <= busy_d;
         frame_q <= frame_d;
         last_q  <= last_d;
         dout_q  <= dout_d;
      end
   end

   // Next-state logic; outputs are derived from the next state so they leave flops
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      par_d   = par_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;

      case (state_q)
         S_IDLE: begin
            if (bus.LOAD) begin
               state_d = S_SEND;
               shift_d = bus.DATAIN;
               par_d   = 2'b00;
               cnt_d   = '0;
            end
         end
         S_SEND: begin
            shift_d = shift_q << 2;
            par_d   = par_q ^ shift_q[WIDTH-1 -: 2];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            if (GAP > 0) begin
               state_d = S_GAPW;
               gap_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GAPW: begin
            gap_d = gap_q + GAP_W'(1);
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d  = (state_d != S_IDLE);
      frame_d = (state_d == S_SEND) || (state_d == S_PARITY);
      last_d  = (state_d == S_PARITY);
      dout_d  = 2'b00;
      if (state_d == S_SEND) begin
         dout_d = shift_d[WIDTH-1 -: 2];
      end else if (state_d == S_PARITY) begin
         dout_d = par_d;
      end
   end

   assign bus.BUSY    = busy_q;
   assign bus.FRAME   = frame_q;
   assign bus.LAST    = last_q;
   assign bus.DATAOUT = dout_q;
endmodule
`default_nettype wire
